// File: rtl/esn_wout_streamer.sv
// Streams a snapshot of the ESN readout weights once per training epoch.
// Each frame is a header word followed by NW weight words on a valid/ready stream.
// The header is placed in the low 32 bits of the word, so WW must be at least 32.
module esn_wout_streamer #(
    parameter int unsigned NW = 8,
    parameter int unsigned WW = 32
) (
    input  logic             clk,
    input  logic             rst_N,
    input  logic             ce,
    input  logic [5:0]       addr,
    input  logic [NW*WW-1:0] W_out,
    output logic [WW-1:0]    m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_last,
    output logic [7:0]       drop_cnt
);

    localparam int unsigned   IW      = $clog2(NW + 1);
    localparam logic [IW-1:0] LastIdx = IW'(NW);

    typedef enum logic {StIdle, StSend} state_e;

    state_e           state_q, state_d;
    logic [5:0]       addr_q;
    logic [15:0]      epoch_q, epoch_d;
    logic [7:0]       drop_q, drop_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [NW*WW-1:0] snap_q, snap_d;
    logic [23:0]      hdr_q, hdr_d;
    logic             trig;
    logic [WW-1:0]    word;

    // Rising into address 63 marks the end of an epoch; holding at 63 does not retrigger.
    assign trig = ce && (addr == 6'd63) && (addr_q != 6'd63);

    // Next-state: capture on an idle trigger, advance on transfer, count triggers lost mid-frame.
    always_comb begin
        state_d = state_q;
        epoch_d = epoch_q;
        drop_d  = drop_q;
        idx_d   = idx_q;
        snap_d  = snap_q;
        hdr_d   = hdr_q;
        if (trig) begin
            epoch_d = epoch_q + 16'd1;
        end
        unique case (state_q)
            StIdle: begin
                if (trig) begin
                    snap_d  = W_out;
                    hdr_d   = {epoch_q, drop_q};
                    idx_d   = '0;
                    state_d = StSend;
                end
            end
            StSend: begin
                if (trig && (drop_q != 8'hFF)) begin
                    drop_d = drop_q + 8'd1;
                end
                if (m_ready) begin
                    if (idx_q == LastIdx) begin
                        idx_d   = '0;
                        state_d = StIdle;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_N) begin
        if (!rst_N) begin
            state_q <= StIdle;
            addr_q  <= '0;
            epoch_q <= '0;
            drop_q  <= '0;
            idx_q   <= '0;
            snap_q  <= '0;
            hdr_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr;
            epoch_q <= epoch_d;
            drop_q  <= drop_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            hdr_q   <= hdr_d;
        end
    end

    // Word select: index 0 is the header, index k is snapshot weight k-1.
    always_comb begin
        word = '0;
        if (idx_q == '0) begin
            word[31:0] = {hdr_q, 8'hA5};
        end
        for (int k = 0; k < int'(NW); k++) begin
            if (idx_q == IW'(k + 1)) begin
                word = snap_q[k*WW +: WW];
            end
        end
    end

    // Outputs are gated by state so reset forces them low immediately.
    always_comb begin
        m_valid  = (state_q == StSend);
        m_data   = m_valid ? word : '0;
        m_last   = m_valid && (idx_q == LastIdx);
        drop_cnt = drop_q;
    end

endmodule
